// File: rtl/line_buffer_ctrl.sv
// line_buffer_ctrl
// Frame sequencer in front of the streaming line buffer. It qualifies camera
// pixels against start-of-frame and tracks the column/row of each pixel. It
// drives the line buffer shift enable, marks pixels that complete a full
// KxK window, and flags end of line, end of frame and stream-sync errors.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   pixel_valid   pixel present on the stream this cycle
//   sof           start-of-frame marker (qualified by pixel_valid)
//   lb_shift_en   combinational: line buffer takes the current pixel
//   out_valid     registered: a pixel was accepted on the previous edge
//   out_col       column of that pixel
//   out_row       row of that pixel
//   window_valid  that pixel is the bottom-right corner of a full window
//   eol           that pixel is the last of its row
//   eof           that pixel is the last of the frame
//   busy          a frame is in progress
//   sync_err      one-cycle pulse on a stream/frame sync violation
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | waiting for sof; non-sof pixels are dropped and flagged
// PRIME  | filling the line buffer (next pixel row < NUM_LINES)
// STREAM | line buffer primed (next pixel row >= NUM_LINES)

module line_buffer_ctrl #(
   parameter  int IMAGE_WIDTH  = 640,
   parameter  int IMAGE_HEIGHT = 480,
   parameter  int NUM_LINES    = 2,
   parameter  int KERNEL_SIZE  = 3,
   localparam int COL_W        = $clog2(IMAGE_WIDTH),
   localparam int ROW_W        = $clog2(IMAGE_HEIGHT)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             pixel_valid,
   input  logic             sof,
   output logic             lb_shift_en,
   output logic             out_valid,
   output logic [COL_W-1:0] out_col,
   output logic [ROW_W-1:0] out_row,
   output logic             window_valid,
   output logic             eol,
   output logic             eof,
   output logic             busy,
   output logic             sync_err
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PRIME  = 2'd1,
      ST_STREAM = 2'd2
   } state_t;

   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(IMAGE_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_WIN    = COL_W'(KERNEL_SIZE - 1);
   localparam logic [COL_W-1:0] COL_ONE    = COL_W'(1);
   localparam logic [ROW_W-1:0] ROW_LAST   = ROW_W'(IMAGE_HEIGHT - 1);
   localparam logic [ROW_W-1:0] ROW_PRIMED = ROW_W'(NUM_LINES);
   localparam logic [ROW_W-1:0] ROW_ONE    = ROW_W'(1);

   state_t           state, state_nxt;
   logic [COL_W-1:0] col, col_nxt;
   logic [ROW_W-1:0] row, row_nxt;

   logic             accept;
   logic             start;
   logic             violation;
   logic [COL_W-1:0] pix_col;
   logic [ROW_W-1:0] pix_row;
   logic             col_wrap;
   logic             frame_end;
   logic             win_hit;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= ST_IDLE;
         col          <= '0;
         row          <= '0;
         out_valid    <= 1'b0;
         out_col      <= '0;
         out_row      <= '0;
         window_valid <= 1'b0;
         eol          <= 1'b0;
         eof          <= 1'b0;
         sync_err     <= 1'b0;
      end else begin
         state        <= state_nxt;
         col          <= col_nxt;
         row          <= row_nxt;
         out_valid    <= accept;
         window_valid <= win_hit;
         eol          <= accept && col_wrap;
         eof          <= accept && frame_end;
         sync_err     <= violation;
         if (accept) begin
            out_col <= pix_col;
            out_row <= pix_row;
         end
      end
   end

   always_comb begin
      state_nxt = state;
      col_nxt   = col;
      row_nxt   = row;

      accept    = pixel_valid && ((state != ST_IDLE) || sof);
      // Any sof pixel starts a new frame at (0,0), truncating a running one.
      start     = pixel_valid && sof;
      // Non-sof pixel while idle, or sof arriving mid-frame.
      violation = pixel_valid && ((state == ST_IDLE) ? !sof : sof);

      pix_col   = start ? '0 : col;
      pix_row   = start ? '0 : row;
      col_wrap  = (pix_col == COL_LAST);
      frame_end = col_wrap && (pix_row == ROW_LAST);
      win_hit   = accept && (pix_row >= ROW_PRIMED) && (pix_col >= COL_WIN);

      if (accept) begin
         if (col_wrap) begin
            col_nxt = '0;
            row_nxt = (pix_row == ROW_LAST) ? '0 : pix_row + ROW_ONE;
         end else begin
            col_nxt = pix_col + COL_ONE;
            row_nxt = pix_row;
         end

         // State follows the row of the next expected pixel.
         if (frame_end) begin
            state_nxt = ST_IDLE;
         end else if (row_nxt >= ROW_PRIMED) begin
            state_nxt = ST_STREAM;
         end else begin
            state_nxt = ST_PRIME;
         end
      end
   end

   assign lb_shift_en = accept;
   assign busy        = (state != ST_IDLE);

endmodule

// File: doc/line_buffer_ctrl.md
# line_buffer_ctrl

Frame sequencer for the streaming `line_buffer` in the vision front-end. It sits between the camera pixel stream and the line buffer plus window/convolution stage. It qualifies incoming pixels against start-of-frame and tracks column and row position. It drives the line buffer shift enable, tells the downstream kernel when a full KxK window is valid, and flags end of line, end of frame and stream-sync errors.

## Interface
- `IMAGE_WIDTH`, 640, pixels per row (≥ KERNEL_SIZE)
- `IMAGE_HEIGHT`, 480, rows per frame (> NUM_LINES)
- `NUM_LINES`, 2, delayed lines held by the line buffer
- `KERNEL_SIZE`, 3, window size; must equal NUM_LINES+1
- `clk`  in  1  system clock
- `rst_n`  in  1  asynchronous, active-low reset
- `pixel_valid`  in  1  pixel present on the stream this cycle
- `sof`  in  1  start-of-frame marker; meaningful only when pixel_valid=1
- `lb_shift_en`  out  1  combinational; line buffer accepts pixel this cycle
- `out_valid`  out  1  registered; pixel accepted in previous cycle
- `out_col`  out  $clog2(IMAGE_WIDTH)  column of that pixel
- `out_row`  out  $clog2(IMAGE_HEIGHT)  row of that pixel
- `window_valid`  out  1  full KxK window available (aligned with out_valid)
- `eol`  out  1  pulse; out_col == IMAGE_WIDTH-1
- `eof`  out  1  pulse; last pixel of frame
- `busy`  out  1  state != IDLE
- `sync_err`  out  1  one-cycle pulse; stream/frame sync violation

## Operation
- States: IDLE, PRIME (row < NUM_LINES), STREAM (row ≥ NUM_LINES).
- Accepted pixel: pixel_valid=1 and (state != IDLE or sof=1). Then `lb_shift_en` = accepted, combinationally in the same cycle.
- IDLE:
  - pixel_valid && sof → pixel accepted as (row 0, col 0); go to PRIME.
  - pixel_valid && !sof → pixel dropped; sync_err pulses; counters unchanged.
- Internal counters col/row hold the position of the next pixel. On every accepted pixel, col increments. At col = IMAGE_WIDTH-1, col wraps to 0 and row increments.
- PRIME → STREAM when the pixel at (NUM_LINES-1, IMAGE_WIDTH-1) is accepted.
- Last pixel (IMAGE_HEIGHT-1, IMAGE_WIDTH-1) accepted → counters clear; state goes to IDLE.
- sof with pixel_valid in PRIME or STREAM (truncated frame):
  - sync_err pulses.
  - The pixel is accepted as (0,0) of a new frame; state goes to PRIME.
  - No eof is issued for the truncated frame.
- window_valid = accepted && row ≥ NUM_LINES && col ≥ KERNEL_SIZE-1, using the position of the pixel itself. The window's bottom-right corner is that pixel.
- Cycles with pixel_valid=0 do not change any state; gaps are allowed anywhere.
- Width rules:
  - Counters compare against IMAGE_WIDTH-1 and IMAGE_HEIGHT-1 exactly and never exceed them.
  - Unused high counter codes are unreachable.

## Timing
- Reset values: all registered outputs 0; state IDLE; counters 0. lb_shift_en is then 0 unless pixel_valid && sof.
- Reset asserted mid-frame clears everything immediately (asynchronous). The next frame requires sof.
- Latency:
  - lb_shift_en: 0 cycles.
  - out_valid, out_col, out_row, window_valid, eol, eof, sync_err: registered, asserted in the cycle after the accepting or violating edge. This matches the line buffer's 1-cycle line_out register.
- eol, eof, window_valid are only ever high together with out_valid. sync_err is not tied to out_valid.
- busy:
  - Rises in the cycle after the first accepted sof pixel.
  - Falls in the cycle after the last pixel, i.e. concurrently with eof.
- Back-to-back frames: sof on the cycle immediately following the last pixel is accepted with no bubble.

## Test plan
Settings for all scenarios: IMAGE_WIDTH=10, IMAGE_HEIGHT=5, NUM_LINES=2, KERNEL_SIZE=3.
- Full frame, continuous: sof with pixel 0, then 49 more pixels.
  - Exactly 50 out_valid cycles.
  - window_valid first after pixel 22 (row 2, col 2), 24 pulses total.
  - eol after pixels 9, 19, …, 49.
  - eof with (4,9).
  - busy low afterwards.
- Pixel before sync: pixel_valid=1, sof=0 while IDLE → lb_shift_en=0, sync_err=1 for one cycle, busy=0, no out_valid.
- Gapped stream: pixel_valid every other cycle for a full frame → identical out_col/out_row sequence and identical 24 window_valid pulses; no outputs in gap cycles.
- Mid-frame resync: sof asserted on pixel 27 → sync_err pulse, out_row/out_col = (0,0), no eof. The next 49 pixels complete the frame with eof at (4,9).
- Async reset mid-frame: rst_n low at pixel 15, between clock edges → all outputs 0 before the next edge. After release, a non-sof pixel gives sync_err; a later sof starts at (0,0).
- Back-to-back frames: new sof on the cycle after pixel 49 → eof and out_valid for (0,0) of frame 2 on consecutive cycles; busy stays high for frame 2.
